// File: rtl/instruction_loader.sv
// Boot-time instruction-memory writer. Packs a big-endian byte stream into
// instruction words and writes them to consecutive word addresses, holding
// the CPU off while the load is in progress.
//
//  state | meaning
//  IDLE  | waiting for start; stream not accepted
//  RECV  | collecting the four bytes of the current word
//  WRITE | single-cycle memory write of the assembled word
//  DONE  | one-cycle completion pulse, then back to IDLE
module instruction_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  abort,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ONE_W = (ADDR_WIDTH + 1)'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     remaining;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [1:0]              byte_idx;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [DATA_WIDTH-1:0]   word_next;
  logic                    consume;

  // Earlier bytes shift toward the MSB, so after four bytes the first one sits on top.
  assign word_next  = {shreg[DATA_WIDTH-BYTE_WIDTH-1:0], byte_in};
  assign byte_ready = (state_q == RECV);
  assign busy       = (state_q == RECV) || (state_q == WRITE);
  assign cpu_hold   = busy;
  // abort wins over a pending handshake
  assign consume    = (state_q == RECV) && byte_valid && !abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (num_words == '0) ? DONE : RECV;
      RECV:    if (abort) state_d = IDLE;
               else if (byte_valid && byte_idx == 2'd3) state_d = WRITE;
      WRITE:   if (abort) state_d = IDLE;
               else if (remaining == ONE_W) state_d = DONE;
               else state_d = RECV;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: byte packing, word/address counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      addr      <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= (state_d == DONE);
      if (state_q == IDLE && start) begin
        remaining <= num_words;
        addr      <= BASE;
        byte_idx  <= '0;
      end
      if (state_q == RECV && abort) byte_idx <= '0;
      if (consume) begin
        shreg    <= word_next;
        byte_idx <= byte_idx + 2'd1;
        // the write strobe is launched with the 4th byte so it is high during WRITE
        if (byte_idx == 2'd3) begin
          mem_we    <= 1'b1;
          mem_addr  <= addr;
          mem_wdata <= word_next;
        end
      end
      if (state_q == WRITE && !abort) begin
        remaining <= remaining - ONE_W;
        addr      <= addr + ONE_A;
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader. Two instances (base 0 and base 8191)
// see the same stimulus; a byte-list model predicts every memory write.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] num_words;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        br0, we0, busy0, hold0, done0;
  logic [12:0] addr0;
  logic [31:0] wd0;
  logic        br1, we1, busy1, hold1, done1;
  logic [12:0] addr1;
  logic [31:0] wd1;

  int n_chk  = 0;
  int n_fail = 0;
  int ndone0 = 0, ndone1 = 0, exp_done = 0;

  logic [7:0]  bytes[$];
  logic [12:0] qa0[$], qa1[$];
  logic [31:0] qd0[$], qd1[$];

  always #5 clk = ~clk;

  instruction_loader #(.BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(br0), .mem_we(we0),
    .mem_addr(addr0), .mem_wdata(wd0), .busy(busy0), .cpu_hold(hold0), .done(done0));

  instruction_loader #(.BASE_ADDR(8191)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(br1), .mem_we(we1),
    .mem_addr(addr1), .mem_wdata(wd1), .busy(busy1), .cpu_hold(hold1), .done(done1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: word i of a load is bytes 4i..4i+3 big-endian at base+i mod 8192
  task automatic expect_words(input int nw);
    for (int i = 0; i < nw; i++) begin
      int w;
      w = bytes[4*i] * 32'h0100_0000 + bytes[4*i+1] * 32'h1_0000 +
          bytes[4*i+2] * 32'h100 + bytes[4*i+3];
      qd0.push_back(32'(w));
      qd1.push_back(32'(w));
      qa0.push_back(13'((0 + i) % 8192));
      qa1.push_back(13'((8191 + i) % 8192));
    end
  endtask

  task automatic fill_random(input int nb);
    bytes.delete();
    for (int i = 0; i < nb; i++) bytes.push_back(8'($urandom));
  endtask

  task automatic fill_fixed();
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  endtask

  // Write monitor: every strobe must match the next predicted write
  always @(negedge clk) begin
    if (rst_n) begin
      if (we0) begin
        if (qa0.size() == 0) chk("unexpected_we_base0", 32'(we0), 32'h0);
        else begin
          chk("addr_base0", 32'(addr0), 32'(qa0.pop_front()));
          chk("data_base0", wd0, qd0.pop_front());
        end
      end
      if (we1) begin
        if (qa1.size() == 0) chk("unexpected_we_base8191", 32'(we1), 32'h0);
        else begin
          chk("addr_base8191", 32'(addr1), 32'(qa1.pop_front()));
          chk("data_base8191", wd1, qd1.pop_front());
        end
      end
      if (done0) ndone0++;
      if (done1) ndone1++;
    end
  end

  // Present bytes[0..nb-1] from the current negedge; returns at the negedge
  // following the edge that consumed the last one. mode 0: always valid,
  // 1: toggling valid, 2: random valid. Start is poked randomly (must be ignored).
  task automatic drive_bytes(input int nb, input int mode);
    int idx = 0;
    int budget = 40 * nb + 40;
    logic v = 1'b0;
    logic pending = 1'b0;
    while (idx < nb && budget > 0) begin
      if (pending) v = 1'b1;
      else if (mode == 0) v = 1'b1;
      else if (mode == 1) v = ~v;
      else v = 1'($urandom_range(0, 1));
      byte_valid = v;
      byte_in    = v ? bytes[idx] : 8'($urandom);
      start      = ($urandom_range(0, 7) == 0);
      num_words  = 14'($urandom);
      pending    = v && !br0;
      if (v && br0) idx++;
      budget--;
      @(negedge clk);
    end
    chk("bytes_consumed", 32'(idx), 32'(nb));
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic run_load(input int nw, input int mode);
    expect_words(nw);
    @(negedge clk);
    start = 1'b1; num_words = 14'(nw); byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; num_words = 14'($urandom);
    exp_done++;
    if (nw == 0) begin
      chk("zero_done", 32'(done0), 32'h1);
      chk("zero_done_wrap", 32'(done1), 32'h1);
      chk("zero_busy", 32'(busy0), 32'h0);
      chk("zero_no_we", 32'(we0), 32'h0);
      @(negedge clk);
      chk("zero_done_single", 32'(done0), 32'h0);
    end else begin
      chk("busy_after_start", 32'(busy0), 32'h1);
      chk("hold_after_start", 32'(hold0), 32'h1);
      chk("ready_after_start", 32'(br0), 32'h1);
      drive_bytes(4 * nw, mode);
      chk("last_we", 32'(we0), 32'h1);
      chk("ready_in_write", 32'(br0), 32'h0);
      chk("no_early_done", 32'(done0), 32'h0);
      @(negedge clk);
      chk("done_after_write", 32'(done0), 32'h1);
      chk("done_after_write_wrap", 32'(done1), 32'h1);
      chk("busy_in_done", 32'(busy0), 32'h0);
      chk("hold_in_done", 32'(hold0), 32'h0);
      @(negedge clk);
      chk("done_single", 32'(done0), 32'h0);
    end
    chk("pending_writes", 32'(qa0.size() + qa1.size()), 32'h0);
    chk("done_count", 32'(ndone0), 32'(exp_done));
    chk("done_count_wrap", 32'(ndone1), 32'(exp_done));
  endtask

  // Abort after k bytes (k not a multiple of 4, so the loader is in RECV)
  task automatic run_abort(input int nw, input int k, input int mode);
    expect_words(k / 4);
    @(negedge clk);
    start = 1'b1; num_words = 14'(nw);
    @(negedge clk);
    start = 1'b0;
    drive_bytes(k, mode);
    abort = 1'b1; byte_valid = 1'b1; byte_in = 8'($urandom);
    @(negedge clk);
    abort = 1'b0; byte_valid = 1'b0;
    chk("abort_busy", 32'(busy0), 32'h0);
    chk("abort_hold", 32'(hold0), 32'h0);
    chk("abort_no_done", 32'(done0), 32'h0);
    repeat (3) @(negedge clk);
    chk("abort_writes", 32'(qa0.size() + qa1.size()), 32'h0);
    chk("abort_done_count", 32'(ndone0), 32'(exp_done));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    32'(we0 | we1), 32'h0);
    chk({tag, "_addr"},  32'(addr0 | addr1), 32'h0);
    chk({tag, "_wdata"}, wd0 | wd1, 32'h0);
    chk({tag, "_done"},  32'(done0 | done1), 32'h0);
    chk({tag, "_busy"},  32'(busy0 | busy1 | hold0 | hold1), 32'h0);
    chk({tag, "_ready"}, 32'(br0 | br1), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; num_words = '0; abort = 1'b0;
    byte_in = '0; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_init");
    rst_n = 1'b1;

    fill_fixed();  run_load(2, 0);
    fill_fixed();  run_load(2, 1);
    run_load(0, 0);

    // reset in the middle of a word, then reload from the base address
    fill_random(12);
    @(negedge clk);
    start = 1'b1; num_words = 14'd3;
    @(negedge clk);
    start = 1'b0;
    drive_bytes(2, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    fill_random(8); run_load(2, 2);

    fill_random(8); run_abort(2, 6, 0);
    fill_fixed();   run_load(2, 0);

    // abort while idle has no effect
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("idle_abort_busy", 32'(busy0), 32'h0);
    chk("idle_abort_done", 32'(ndone0), 32'(exp_done));

    for (int it = 0; it < 24; it++) begin
      int nw, mode, k;
      nw   = $urandom_range(1, 5);
      mode = $urandom_range(0, 2);
      fill_random(4 * nw);
      if ($urandom_range(0, 3) == 0) begin
        do k = $urandom_range(1, 4 * nw - 1); while (k % 4 == 0);
        run_abort(nw, k, mode);
      end else begin
        run_load(nw, mode);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
